// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback scheduler: requester ids
// and the address-width derivation used by every port that names a register.
package regfile_pkg;

  typedef enum logic {
    WB_ALU  = 1'b0,
    WB_LOAD = 1'b1
  } wb_req_e;

  // A single-entry file still needs a one-bit address.
  function automatic int addr_w(input int n);
    if (n > 32'sd1) begin
      return $clog2(n);
    end else begin
      return 32'sd1;
    end
  endfunction

endpackage

// File: rtl/wb_rr_arb2.sv
// Two-requester round-robin grant for the writeback port. Grants are
// combinational; the one-bit priority pointer is the only state.
module wb_rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  output logic [1:0] grant_o
);

  wb_req_e    ptr_q;
  wb_req_e    ptr_d;
  logic [1:0] grant_s;

  // Contention goes to the pointer's requester; readies stay low in reset.
  always_comb begin
    grant_s = 2'b00;
    if (!rst) begin
      grant_s = 2'b00;
    end else if (valid_i == 2'b11) begin
      grant_s = (ptr_q == WB_ALU) ? 2'b01 : 2'b10;
    end else begin
      grant_s = valid_i;
    end
  end

  // After a grant the other requester gets priority.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_s[0]) begin
      ptr_d = WB_LOAD;
    end else if (grant_s[1]) begin
      ptr_d = WB_ALU;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= WB_ALU;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign grant_o = grant_s;

endmodule

// File: rtl/regfile_wb_sched.sv
// Writeback scheduler: arbitrates ALU and load writebacks onto the single
// register-file write port and tracks pending destinations for hazard checks.
module regfile_wb_sched
  import regfile_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int REG_NUM    = 32,
  localparam int ADDR_W     = addr_w(REG_NUM)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb0_valid,
  output logic                  wb0_ready,
  input  logic [ADDR_W-1:0]     wb0_addr,
  input  logic [DATA_WIDTH-1:0] wb0_data,
  input  logic                  wb1_valid,
  output logic                  wb1_ready,
  input  logic [ADDR_W-1:0]     wb1_addr,
  input  logic [DATA_WIDTH-1:0] wb1_data,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_wren,
  input  logic                  resv_valid,
  input  logic [ADDR_W-1:0]     resv_addr,
  input  logic [ADDR_W-1:0]     rs1_addr,
  input  logic [ADDR_W-1:0]     rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy
);

  // One-hot select of a register; out-of-range addresses select nothing.
  function automatic logic [REG_NUM-1:0] addr_mask(input logic [ADDR_W-1:0] a, input logic en);
    addr_mask = '0;
    if (en && (int'(a) < REG_NUM)) begin
      addr_mask[a] = 1'b1;
    end else begin
      addr_mask = '0;
    end
  endfunction

  logic [1:0]            grant_s;
  logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_wren_q, rd_wren_d;
  logic [REG_NUM-1:0]    busy_q, busy_d;
  logic [REG_NUM-1:0]    set_s, clr_s;

  wb_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .valid_i ({wb1_valid, wb0_valid}),
    .grant_o (grant_s)
  );

  assign wb0_ready = grant_s[0];
  assign wb1_ready = grant_s[1];

  // Capture the granted writeback; register 0 is accepted but never written.
  always_comb begin
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    rd_wren_d = 1'b0;
    if (grant_s[1]) begin
      rd_addr_d = wb1_addr;
      rd_data_d = wb1_data;
      rd_wren_d = (wb1_addr != '0);
    end else if (grant_s[0]) begin
      rd_addr_d = wb0_addr;
      rd_data_d = wb0_data;
      rd_wren_d = (wb0_addr != '0);
    end else begin
      rd_addr_d = rd_addr_q;
      rd_data_d = rd_data_q;
      rd_wren_d = 1'b0;
    end
  end

  // A reservation on the commit edge of the same register wins, so the
  // older result retires without hiding the newer pending write.
  assign set_s  = addr_mask(resv_addr, resv_valid && (resv_addr != '0));
  assign clr_s  = addr_mask(rd_addr_q, rd_wren_q);
  assign busy_d = ((busy_q & ~clr_s) | set_s) & {{(REG_NUM-1){1'b1}}, 1'b0};

  // Write-port and scoreboard registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_addr_q <= '0;
      rd_data_q <= '0;
      rd_wren_q <= 1'b0;
      busy_q    <= '0;
    end else begin
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      rd_wren_q <= rd_wren_d;
      busy_q    <= busy_d;
    end
  end

  assign rd_addr  = rd_addr_q;
  assign rd_data  = rd_data_q;
  assign rd_wren  = rd_wren_q;
  assign rs1_busy = |(busy_q & addr_mask(rs1_addr, 1'b1));
  assign rs2_busy = |(busy_q & addr_mask(rs2_addr, 1'b1));

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Scoreboard bench for regfile_wb_sched: stimulus pushes expected commits,
// a negedge monitor pops and compares whatever the write port presents.
module tb_regfile_wb_sched;

  logic        clk, rst;
  logic        wb0_valid, wb0_ready, wb1_valid, wb1_ready;
  logic [4:0]  wb0_addr, wb1_addr, rd_addr, resv_addr, rs1_addr, rs2_addr;
  logic [31:0] wb0_data, wb1_data, rd_data;
  logic        rd_wren, resv_valid, rs1_busy, rs2_busy;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  regfile_wb_sched dut (
    .clk(clk), .rst(rst),
    .wb0_valid(wb0_valid), .wb0_ready(wb0_ready), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_valid(wb1_valid), .wb1_ready(wb1_ready), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_wren(rd_wren),
    .resv_valid(resv_valid), .resv_addr(resv_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive both requesters; g is the requester expected to win (-1: none).
  task automatic drive_wb(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                          input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                          input int g);
    exp_t e;
    wb0_valid = v0; wb0_addr = a0; wb0_data = d0;
    wb1_valid = v1; wb1_addr = a1; wb1_data = d1;
    #1;
    chk("wb0_ready", {31'd0, wb0_ready}, {31'd0, (g == 0)});
    chk("wb1_ready", {31'd0, wb1_ready}, {31'd0, (g == 1)});
    if (g == 0 && a0 != 5'd0) begin
      e.addr = a0; e.data = d0; e.due = cyc + 1; sb.push_back(e);
    end else if (g == 1 && a1 != 5'd0) begin
      e.addr = a1; e.data = d1; e.due = cyc + 1; sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (rd_wren === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=addr %0h data %0h expected=no write", rd_addr, rd_data);
      end else begin
        mon_e = sb.pop_front();
        chk("wr_addr", {27'd0, rd_addr}, {27'd0, mon_e.addr});
        chk("wr_data", rd_data, mon_e.data);
        chk("wr_cycle", cyc, mon_e.due);
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      checks++;
      failures++;
      $display("FAIL missing_write actual=no write expected=addr %0h data %0h", sb[0].addr, sb[0].data);
      void'(sb.pop_front());
    end
  end

  initial begin
    rst = 1'b0;
    wb0_valid = 1'b0; wb0_addr = 5'd0; wb0_data = 32'd0;
    wb1_valid = 1'b0; wb1_addr = 5'd0; wb1_data = 32'd0;
    resv_valid = 1'b0; resv_addr = 5'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
    step();
    step();
    // Reset state, readies held low despite valid requests.
    drive_wb(1'b1, 5'd3, 32'h3, 1'b1, 5'd4, 32'h4, -1);
    chk("rst_rd_wren", {31'd0, rd_wren}, 32'd0);
    chk("rst_rd_addr", {27'd0, rd_addr}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_rs1_busy", {31'd0, rs1_busy}, 32'd0);
    step();

    // Both valid from reset: grants alternate 0,1,0,1.
    rst = 1'b1;
    drive_wb(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 0);
    step();
    drive_wb(1'b1, 5'd3, 32'h33, 1'b1, 5'd2, 32'h22, 1);
    step();
    drive_wb(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 0);
    step();
    drive_wb(1'b1, 5'd6, 32'h66, 1'b1, 5'd4, 32'h44, 1);
    step();
    drive_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, -1);
    step();

    // Single ALU writeback.
    drive_wb(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 0);
    step();
    drive_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, -1);
    step();

    // Address 0: accepted, never written, never busy.
    drive_wb(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'h0, 0);
    step();
    drive_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, -1);
    chk("zero_rd_wren", {31'd0, rd_wren}, 32'd0);
    resv_valid = 1'b1; resv_addr = 5'd0; rs1_addr = 5'd0;
    step();
    resv_valid = 1'b0;
    chk("zero_rs1_busy", {31'd0, rs1_busy}, 32'd0);

    // Reserve 7, load unit writes it back two cycles later.
    resv_valid = 1'b1; resv_addr = 5'd7; rs1_addr = 5'd7;
    step();
    resv_valid = 1'b0;
    chk("r7_busy_set", {31'd0, rs1_busy}, 32'd1);
    step();
    drive_wb(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77, 1);
    chk("r7_busy_hold", {31'd0, rs1_busy}, 32'd1);
    step();
    drive_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, -1);
    chk("r7_busy_commit_cycle", {31'd0, rs1_busy}, 32'd1);
    step();
    chk("r7_busy_cleared", {31'd0, rs1_busy}, 32'd0);

    // Reservation of 9 on the edge that commits 9: set wins.
    drive_wb(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0, 0);
    step();
    drive_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, -1);
    resv_valid = 1'b1; resv_addr = 5'd9; rs2_addr = 5'd9;
    #1;
    chk("r9_busy_before", {31'd0, rs2_busy}, 32'd0);
    step();
    resv_valid = 1'b0;
    chk("r9_busy_after", {31'd0, rs2_busy}, 32'd1);
    chk("r7_busy_still_clear", {31'd0, rs1_busy}, 32'd0);

    // Reserve 12, then reset in the middle of a contended stream.
    resv_valid = 1'b1; resv_addr = 5'd12; rs1_addr = 5'd12;
    step();
    resv_valid = 1'b0;
    chk("r12_busy_set", {31'd0, rs1_busy}, 32'd1);
    drive_wb(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB0, 1);
    step();
    drive_wb(1'b1, 5'd10, 32'hA0, 1'b1, 5'd13, 32'hB1, 0);
    step();
    drive_wb(1'b1, 5'd14, 32'hA1, 1'b1, 5'd13, 32'hB1, 1);
    #1;
    rst = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_rd_wren", {31'd0, rd_wren}, 32'd0);
    chk("mid_rst_wb0_ready", {31'd0, wb0_ready}, 32'd0);
    chk("mid_rst_wb1_ready", {31'd0, wb1_ready}, 32'd0);
    chk("mid_rst_r12_busy", {31'd0, rs1_busy}, 32'd0);
    chk("mid_rst_r9_busy", {31'd0, rs2_busy}, 32'd0);
    step();
    drive_wb(1'b1, 5'd14, 32'hA1, 1'b1, 5'd13, 32'hB1, -1);
    step();
    rst = 1'b1;
    drive_wb(1'b1, 5'd14, 32'hA1, 1'b1, 5'd13, 32'hB1, 0);
    step();
    drive_wb(1'b1, 5'd15, 32'hA2, 1'b1, 5'd13, 32'hB1, 1);
    step();
    drive_wb(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, -1);
    step();
    step();
    chk("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
